// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared types and constants for the 4x4 hex keypad scanner.
//   - db_state_e    : debounce state machine states
//   - scan_result_e : outcome of one full keypad scan
//   - KEY_MAP       : hex code of each key, indexed by {row, col}
//   - COL_SELECT    : active-low one-hot column strobe for each column
//   - pressed_count / pressed_row : helpers over active-low row vectors
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HELD,
        RELEASE
    } db_state_e;

    typedef enum logic [1:0] {
        SCAN_NONE,
        SCAN_KEY,
        SCAN_MULTI
    } scan_result_e;

    // Entry {row, col}. Rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    localparam logic [3:0][3:0] COL_SELECT = {
        4'b0111, 4'b1011, 4'b1101, 4'b1110
    };

    // Number of pressed (low) rows in an active-low row vector.
    function automatic logic [2:0] pressed_count(input logic [3:0] rows_n);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, ~rows_n[i]};
        end
        return n;
    endfunction

    // Index of the lowest pressed row; only meaningful when exactly one is pressed.
    function automatic logic [1:0] pressed_row(input logic [3:0] rows_n);
        logic [1:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_n[i]) begin
                r = 2'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce
//   Debounce state machine advanced once per completed keypad scan.
//   A key is accepted after DEBOUNCE_SCANS consecutive identical single-key
//   scans; it must then be released for DEBOUNCE_SCANS consecutive empty
//   scans before another key can be accepted (no auto-repeat).
// Ports:
//   clk         : system clock
//   reset       : synchronous active-high reset
//   scan_valid  : high for the one cycle a scan result is presented
//   scan_result : NONE / KEY / MULTI for the completed scan
//   scan_code   : hex code of the key when scan_result is KEY
//   accept      : combinational, high in the cycle a key is accepted
//   accept_code : code of the accepted key (valid with accept)
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         scan_valid,
    input  scan_result_e scan_result,
    input  logic [3:0]   scan_code,
    output logic         accept,
    output logic [3:0]   accept_code
);

    localparam logic [3:0] TARGET = 4'(DEBOUNCE_SCANS);

    db_state_e  state, state_next;
    logic [3:0] count, count_next;
    logic [3:0] cand, cand_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            cand  <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            cand  <= cand_next;
        end
    end

    always_comb begin
        state_next  = state;
        count_next  = count;
        cand_next   = cand;
        accept      = 1'b0;
        accept_code = scan_code;

        if (scan_valid) begin
            case (state)
                IDLE: begin
                    if (scan_result == SCAN_KEY) begin
                        if (TARGET == 4'd1) begin
                            accept     = 1'b1;
                            state_next = HELD;
                            count_next = '0;
                        end else begin
                            state_next = PRESS;
                            cand_next  = scan_code;
                            count_next = 4'd1;
                        end
                    end
                end

                PRESS: begin
                    if (scan_result == SCAN_KEY) begin
                        if (scan_code == cand) begin
                            if (count + 4'd1 >= TARGET) begin
                                accept     = 1'b1;
                                state_next = HELD;
                                count_next = '0;
                            end else begin
                                count_next = count + 4'd1;
                            end
                        end else begin
                            // A different key restarts the qualification.
                            cand_next  = scan_code;
                            count_next = 4'd1;
                        end
                    end else begin
                        state_next = IDLE;
                        count_next = '0;
                    end
                end

                HELD: begin
                    if (scan_result == SCAN_NONE) begin
                        if (TARGET == 4'd1) begin
                            state_next = IDLE;
                            count_next = '0;
                        end else begin
                            state_next = RELEASE;
                            count_next = 4'd1;
                        end
                    end
                end

                RELEASE: begin
                    if (scan_result == SCAN_NONE) begin
                        if (count + 4'd1 >= TARGET) begin
                            state_next = IDLE;
                            count_next = '0;
                        end else begin
                            count_next = count + 4'd1;
                        end
                    end else begin
                        state_next = HELD;
                        count_next = '0;
                    end
                end

                default: begin
                    state_next = IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/keypad_hex_entry.sv
// keypad_hex_entry
//   Scans a 4x4 hex keypad and shifts each accepted key into a 16-bit value
//   (most recent digit in [3:0]) for a 4-digit hex display.
//   Optional macro KEYPAD_BACKSPACE_EN: an accepted E shifts value right
//   (backspace) instead of being entered as a digit.
// Ports:
//   clk       : system clock, all logic on posedge
//   reset     : synchronous active-high reset
//   rows      : keypad rows, active-low, asynchronous to clk
//   colselect : column strobe, active-low one-hot
//   value     : entered hex digits
//   key_code  : code of the last accepted key, held until the next one
//   key_valid : one-cycle pulse per accepted key
module keypad_hex_entry
    import keypad_pkg::*;
#(
    parameter int DWELL_BITS     = 17,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  rows,
    output logic [3:0]  colselect,
    output logic [15:0] value,
    output logic [3:0]  key_code,
    output logic        key_valid
);

    logic [3:0]            rows_meta;
    logic [3:0]            rows_sync;
    logic [DWELL_BITS-1:0] dwell;
    logic [1:0]            col;
    logic [1:0]            acc_count;   // pressed positions so far: 0, 1, 2 = two or more
    logic [3:0]            acc_code;

    logic                  sample;
    logic [2:0]            col_hits;
    logic [1:0]            hit_row;
    logic [1:0]            base_count;
    logic [2:0]            sum_count;
    logic [1:0]            merged_count;
    logic [3:0]            merged_code;
    logic                  scan_valid;
    scan_result_e          scan_result;
    logic                  accept;
    logic [3:0]            accept_code;

    assign sample    = &dwell;
    assign colselect = COL_SELECT[col];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rows_meta <= 4'hF;
            rows_sync <= 4'hF;
            dwell     <= '0;
            col       <= '0;
            acc_count <= '0;
            acc_code  <= '0;
        end else begin
            rows_meta <= rows;
            rows_sync <= rows_meta;
            dwell     <= dwell + DWELL_BITS'(1);
            if (sample) begin
                col       <= col + 2'd1;
                acc_count <= merged_count;
                acc_code  <= merged_code;
            end
        end
    end

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        col_hits     = pressed_count(rows_sync);
        hit_row      = pressed_row(rows_sync);
        // Column 0 opens a new scan, so the previous scan's tally is dropped.
        base_count   = (col == 2'd0) ? 2'd0 : acc_count;
        sum_count    = {1'b0, base_count} + col_hits;
        merged_count = (sum_count >= 3'd2) ? 2'd2 : sum_count[1:0];
        merged_code  = acc_code;
        if (col_hits == 3'd1) begin
            merged_code = KEY_MAP[{hit_row, col}];
        end

        scan_valid  = sample && (col == 2'd3);
        scan_result = SCAN_MULTI;
        if (merged_count == 2'd0) begin
            scan_result = SCAN_NONE;
        end else if (merged_count == 2'd1) begin
            scan_result = SCAN_KEY;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk         (clk),
        .reset       (reset),
        .scan_valid  (scan_valid),
        .scan_result (scan_result),
        .scan_code   (merged_code),
        .accept      (accept),
        .accept_code (accept_code)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            value     <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= accept;
            if (accept) begin
                key_code <= accept_code;
`ifdef KEYPAD_BACKSPACE_EN
                if (accept_code == 4'hE) begin
                    value <= {4'h0, value[15:4]};
                end else begin
                    value <= {value[11:0], accept_code};
                end
`else
                value <= {value[11:0], accept_code};
`endif
            end
        end
    end

endmodule

// File: tb/tb_keypad_hex_entry.sv
// tb_keypad_hex_entry
//   Bench for keypad_hex_entry with DWELL_BITS=2 (16 cycles per scan) and
//   DEBOUNCE_SCANS=3. A keypad matrix model turns a set of pressed key
//   positions (bit row*4+col) into active-low rows from colselect.
//   Phases: table-driven scan sequences, hand-written reset/backspace
//   sequences, then random key activity against a reference model.
module tb_keypad_hex_entry;

    localparam int DWELL_BITS  = 2;
    localparam int DS          = 3;
    localparam int DWELL       = 1 << DWELL_BITS;
    localparam int SCAN_CYCLES = 4 * DWELL;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  rows;
    logic [3:0]  colselect;
    logic [15:0] value;
    logic [3:0]  key_code;
    logic        key_valid;

    logic [15:0] pressed = '0;
    logic [3:0]  exp_key_code = '0;
    int          checks = 0;
    int          errors = 0;

    // Keypad legend in row-major order: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D.
    logic [3:0] tb_keys [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'h0, 4'hF, 4'hE, 4'hD};

    keypad_hex_entry #(
        .DWELL_BITS     (DWELL_BITS),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .colselect (colselect),
        .value     (value),
        .key_code  (key_code),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    // Switch matrix: a pressed key pulls its row low while its column is strobed.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !colselect[c]) begin
                    rows[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] key_bit(input int idx);
        return 16'(1) << idx;
    endfunction

    function automatic logic [3:0] col_pattern(input int c);
        logic [3:0] p;
        p = 4'hF;
        p[c] = 1'b0;
        return p;
    endfunction

    // Synchronous reset for two cycles; leaves the DUT at the start of a scan.
    task automatic apply_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset colselect", colselect, 4'b1110);
        check("reset value", value, 16'h0000);
        check("reset key_code", key_code, 4'h0);
        check("reset key_valid", key_valid, 1'b0);
        exp_key_code = 4'h0;
        reset = 1'b0;
    endtask

    // One full scan with a fixed set of pressed keys; the accept pulse for this
    // scan lands on the first cycle of the following scan.
    task automatic run_scan(input logic [15:0] mask, input bit exp_pulse,
                            input logic [3:0] exp_code, input logic [15:0] exp_value);
        pressed = mask;
        for (int j = 1; j <= SCAN_CYCLES; j++) begin
            @(posedge clk);
            #1;
            check("colselect", colselect, col_pattern((j / DWELL) % 4));
            check("key_valid", key_valid, (j == SCAN_CYCLES) && exp_pulse);
        end
        if (exp_pulse) exp_key_code = exp_code;
        check("key_code", key_code, exp_key_code);
        check("value", value, exp_value);
    endtask

    // ---------------- table of scan vectors ----------------
    typedef struct {
        bit          do_reset;
        logic [15:0] mask;
        bit          exp_pulse;
        logic [3:0]  exp_code;
        logic [15:0] exp_value;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] tbl_value = '0;

    task automatic add_reset();
        vecs.push_back('{do_reset: 1'b1, mask: 16'h0, exp_pulse: 1'b0, exp_code: 4'h0, exp_value: 16'h0});
        tbl_value = 16'h0;
    endtask

    task automatic add_hold(input logic [15:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            vecs.push_back('{do_reset: 1'b0, mask: mask, exp_pulse: 1'b0, exp_code: 4'h0, exp_value: tbl_value});
        end
    endtask

    task automatic add_press(input logic [15:0] mask, input logic [3:0] code, input logic [15:0] new_value);
        add_hold(mask, DS - 1);
        tbl_value = new_value;
        vecs.push_back('{do_reset: 1'b0, mask: mask, exp_pulse: 1'b1, exp_code: code, exp_value: new_value});
    endtask

    // ---------------- reference model ----------------
    bit          m_locked;
    int          m_run;
    int          m_none_run;
    logic [3:0]  m_key;
    logic [15:0] m_value;

    task automatic model_reset();
        m_locked   = 1'b0;
        m_run      = 0;
        m_none_run = 0;
        m_key      = 4'h0;
        m_value    = 16'h0;
    endtask

    // A key is taken after DS consecutive scans showing only that key; the next
    // one needs DS consecutive empty scans first.
    task automatic model_step(input logic [15:0] mask, output bit pulse, output logic [3:0] code);
        int         n;
        logic [3:0] k;
        n = $countones(mask);
        k = 4'h0;
        pulse = 1'b0;
        code = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (mask[i]) k = tb_keys[i];
        end
        if (!m_locked) begin
            if (n == 1) begin
                if (m_run > 0 && k == m_key) begin
                    m_run++;
                end else begin
                    m_key = k;
                    m_run = 1;
                end
                if (m_run == DS) begin
                    pulse = 1'b1;
                    code = k;
                    m_locked = 1'b1;
                    m_run = 0;
                    m_none_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (n == 0) begin
                m_none_run++;
                if (m_none_run == DS) m_locked = 1'b0;
            end else begin
                m_none_run = 0;
            end
        end
        if (pulse) begin
`ifdef KEYPAD_BACKSPACE_EN
            if (k == 4'hE) m_value = {4'h0, m_value[15:4]};
            else           m_value = {m_value[11:0], k};
`else
            m_value = {m_value[11:0], k};
`endif
        end
    endtask

    task automatic enter_key(input int idx, input logic [3:0] code, input logic [15:0] new_value,
                             input logic [15:0] old_value);
        for (int s = 1; s <= DS; s++) begin
            run_scan(key_bit(idx), s == DS, code, (s == DS) ? new_value : old_value);
        end
        for (int s = 0; s < DS; s++) begin
            run_scan(16'h0, 1'b0, 4'h0, new_value);
        end
    endtask

    initial begin
        bit          pulse;
        logic [3:0]  code;
        logic [15:0] mask;
        int          a;
        int          b;
        int          n;
        int          sel;

        // Idle, then key 2 held past acceptance, then key 0.
        add_hold(16'h0, 10);
        add_press(key_bit(1), 4'h2, 16'h0002);
        add_hold(key_bit(1), 2);
        add_hold(16'h0, 3);
        add_press(key_bit(12), 4'h0, 16'h0020);
        add_hold(16'h0, 3);
        // Short burst of 7 rejected; second burst accepted; bouncy release.
        add_reset();
        add_hold(key_bit(8), 2);
        add_hold(16'h0, 1);
        add_press(key_bit(8), 4'h7, 16'h0007);
        add_hold(16'h0, 1);
        add_hold(key_bit(8), 1);
        add_hold(16'h0, 3);
        // Five digits: the first one falls off the top.
        add_reset();
        add_press(key_bit(0), 4'h1, 16'h0001);
        add_hold(16'h0, 3);
        add_press(key_bit(1), 4'h2, 16'h0012);
        add_hold(16'h0, 3);
        add_press(key_bit(2), 4'h3, 16'h0123);
        add_hold(16'h0, 3);
        add_press(key_bit(3), 4'hA, 16'h123A);
        add_hold(16'h0, 3);
        add_press(key_bit(7), 4'hB, 16'h23AB);
        add_hold(16'h0, 3);
        // Two keys together never qualify; a lone 5 afterwards does.
        add_hold(key_bit(5) | key_bit(6), 6);
        add_press(key_bit(5), 4'h5, 16'h3AB5);
        add_hold(16'h0, 3);

        apply_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_reset) apply_reset();
            else run_scan(vecs[i].mask, vecs[i].exp_pulse, vecs[i].exp_code, vecs[i].exp_value);
        end

        // Reset in the middle of qualifying key 9, key still held throughout.
        run_scan(key_bit(10), 1'b0, 4'h0, 16'h3AB5);
        run_scan(key_bit(10), 1'b0, 4'h0, 16'h3AB5);
        repeat (7) @(posedge clk);
        apply_reset();
        run_scan(key_bit(10), 1'b0, 4'h0, 16'h0000);
        run_scan(key_bit(10), 1'b0, 4'h0, 16'h0000);
        run_scan(key_bit(10), 1'b1, 4'h9, 16'h0009);
        run_scan(16'h0, 1'b0, 4'h0, 16'h0009);
        run_scan(16'h0, 1'b0, 4'h0, 16'h0009);
        run_scan(16'h0, 1'b0, 4'h0, 16'h0009);

        // Key E on 1234: backspace when enabled, otherwise an ordinary digit.
        apply_reset();
        enter_key(0, 4'h1, 16'h0001, 16'h0000);
        enter_key(1, 4'h2, 16'h0012, 16'h0001);
        enter_key(2, 4'h3, 16'h0123, 16'h0012);
        enter_key(4, 4'h4, 16'h1234, 16'h0123);
`ifdef KEYPAD_BACKSPACE_EN
        enter_key(14, 4'hE, 16'h0123, 16'h1234);
`else
        enter_key(14, 4'hE, 16'h234E, 16'h1234);
`endif

        // Random key activity against the reference model.
        model_reset();
        apply_reset();
        for (int seg = 0; seg < 40; seg++) begin
            sel = $urandom_range(0, 99);
            if (sel < 45) begin
                mask = 16'h0;
            end else if (sel < 85) begin
                mask = key_bit($urandom_range(0, 15));
            end else begin
                a = $urandom_range(0, 15);
                b = (a + 1 + $urandom_range(0, 14)) % 16;
                mask = key_bit(a) | key_bit(b);
            end
            n = $urandom_range(1, 5);
            for (int s = 0; s < n; s++) begin
                model_step(mask, pulse, code);
                run_scan(mask, pulse, code, m_value);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_hex_entry.md
Name: keypad_hex_entry

Overview:
- Input-side counterpart of the multiplexed 4-digit hex display: scans a 4x4 hex keypad and assembles keypresses into a 16-bit value.
- Drives active-low column strobes, reads active-low rows, debounces, and shifts each accepted hex digit into the low nibble of `value`.
- `value` feeds the display's 16-bit input directly. Its most recent digit appears on the rightmost digit.

Parameters:
- DWELL_BITS, 17: each column is strobed for 2^DWELL_BITS clk cycles.
- DEBOUNCE_SCANS, 4: number of consecutive identical full scans needed to accept a press or a release (range 1..15).

Ports:
- clk, input, 1: single system clock; all logic is on posedge.
- reset, input, 1: synchronous, active-high reset.
- rows, input, 4: keypad rows, active-low, externally pulled up, asynchronous to clk.
- colselect, output, 4: column strobe, active-low one-hot.
- value, output, 16: entered hex digits; most recent digit in [3:0].
- key_code, output, 4: hex code of the last accepted key; held until the next accepted key.
- key_valid, output, 1: one-cycle pulse when a key is accepted.

Behaviour:
- Reset values:
  - colselect = 4'b1110 (column 0).
  - Dwell counter = 0, scan accumulator cleared, state = IDLE, debounce count = 0.
  - value = 16'h0000, key_code = 4'h0, key_valid = 0.
- Reset mid-operation aborts everything. A key still held after reset must pass a full fresh debounce.
- Row synchronisation: rows pass through a 2-flop synchroniser before use. Pressed means the synchronised bit is 0.
- Column scan:
  - The dwell counter increments every cycle.
  - When the counter is all ones, the synchronised rows are sampled for the current column. On the next cycle the column advances 0→1→2→3→0, i.e. colselect cycles 1110→1101→1011→0111.
  - One full scan = 4·2^DWELL_BITS cycles.
- Scan result, evaluated at the column-3 sample:
  - NONE: zero pressed positions.
  - KEY(code): exactly one pressed position.
  - MULTI: two or more pressed positions.
- Key map (row r, column c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Debounce state machine, advanced once per scan result:
  - IDLE:
    - KEY(k) → PRESS, candidate = k, count = 1.
    - If DEBOUNCE_SCANS == 1, go directly to accept.
  - PRESS:
    - Same KEY(k): count++. When count reaches DEBOUNCE_SCANS → accept, go to HELD.
    - A different KEY: restart with candidate = the new key, count = 1.
    - NONE or MULTI → IDLE.
  - HELD:
    - NONE → RELEASE, count = 1.
    - KEY and MULTI stay in HELD. There is no auto-repeat.
  - RELEASE:
    - NONE: count++. When count reaches DEBOUNCE_SCANS → IDLE.
    - Any KEY or MULTI → HELD.
- Accept, registered on the cycle after the deciding column-3 sample. In that cycle:
  - value ← {value[11:0], k}.
  - key_code ← k.
  - key_valid = 1 for exactly 1 cycle.
- Press-to-accept latency: DEBOUNCE_SCANS scans after the first qualifying scan, plus 1 cycle. The 2-flop synchroniser adds up to 2 cycles ahead of that.
- Wrap-around:
  - The fifth digit shifts value[15:12] out and discards it.
  - The dwell counter wraps freely.

Optional Feature:
- Macro: KEYPAD_BACKSPACE_EN.
- With the macro defined: an accepted key E is a backspace, and value ← {4'h0, value[15:4]}. key_code = E and key_valid still pulse as normal.
- Without the macro: E is an ordinary digit and is shifted in like any other key.

Decomposition:
- Shared package keypad_pkg contains:
  - Debounce state enum: IDLE, PRESS, HELD, RELEASE.
  - Scan-result encoding: NONE, KEY, MULTI.
  - The 16-entry key-map constant indexed by {row, col}.
  - Column one-hot constants.
- Sub-module keypad_debounce:
  - Takes the per-scan result and code, and returns accept plus the accepted code.
  - Keeps the scan/timing logic and value register in the top module.

Test Plan (DWELL_BITS=2 → 16 cycles per scan; DEBOUNCE_SCANS=3):
1. Reset, then idle (rows=4'hF) for 10 scans → colselect cycles 1110,1101,1011,0111 every 4 cycles; value=0000; key_valid never 1.
2. Hold r0/c1 for 5 scans, release, then hold r3/c0 → key_valid pulses once per key; key_code=2 then 0; value=0020.
3. Key 7 for 2 scans, release 1 scan, key 7 for 3 scans → only the second burst is accepted; value=0007. Then bounce release as none, key, none, none, none → no second pulse.
4. Enter 1,2,3,A,B → value=23AB, 5 pulses.
5. Press 5 and 6 together for 6 scans → no pulse. Then press 5 alone for 3 scans → value ends in 5.
6. Assert reset mid-PRESS (after 2 scans of key 9) while still holding 9 → outputs back to reset values; 9 accepted 3 scans after reset deasserts. With KEYPAD_BACKSPACE_EN, pressing E on 1234 gives 0123.
